// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: per-channel state
// encodings and default timing constants for a 50 MHz system clock.
package btn_pkg;

  // Per-channel FSM state encodings
  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDebPress = 2'd1;
  localparam logic [1:0] StDown     = 2'd2;
  localparam logic [1:0] StDebRel   = 2'd3;

  // Defaults for a 50 MHz clock: 1 ms tick, 20 ms debounce, 1 s hold, 200 ms repeat
  localparam int unsigned DefTickDiv       = 50000;
  localparam int unsigned DefDebounceTicks = 20;
  localparam int unsigned DefHoldTicks     = 1000;
  localparam int unsigned DefRepeatTicks   = 200;

endpackage

// File: rtl/btn_channel_fsm.sv
// One channel of the button conditioner: tick-based debounce FSM, press /
// release pulses, long-press hold detection and, when BTN_AUTOREPEAT_EN is
// defined, auto-repeat press pulses while held.
module btn_channel_fsm
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
  parameter int unsigned HOLD_TICKS     = DefHoldTicks
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_TICKS   = DefRepeatTicks
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic s_i,
  input  logic tick_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic held_o
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HcntW = $clog2(HOLD_TICKS + 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [HcntW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             hold_q, hold_d;
  logic             deb_done;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  logic [RepW-1:0] rcnt_q, rcnt_d, rcnt_inc;
`endif

  assign cnt_inc  = cnt_q + 1'b1;
  assign hcnt_inc = hcnt_q + 1'b1;
  // cnt is zero on entry to DEB_PRESS/DEB_REL, so this also covers DEBOUNCE_TICKS == 1
  assign deb_done = (cnt_inc == CntW'(DEBOUNCE_TICKS));

  // Next-state logic for debounce, hold and pulse generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    held_d    = held_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;

    case (state_q)
      StIdle, StDebPress: begin
        if (!s_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (deb_done) begin
            state_d = StDown;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            state_d = StDebPress;
            cnt_d   = cnt_inc;
          end
        end
      end
      StDown, StDebRel: begin
        if (s_i) begin
          // A release bounce returns to DOWN with hcnt/held untouched
          state_d = StDown;
          cnt_d   = '0;
          if (tick_i && (state_q == StDown) && (hcnt_q != HcntW'(HOLD_TICKS))) begin
            hcnt_d = hcnt_inc;
            if (hcnt_inc == HcntW'(HOLD_TICKS)) begin
              hold_d = 1'b1;
              held_d = 1'b1;
            end
          end
        end else if (tick_i) begin
          if (deb_done) begin
            state_d   = StIdle;
            cnt_d     = '0;
            hcnt_d    = '0;
            held_d    = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = StDebRel;
            cnt_d   = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        hcnt_d  = '0;
        held_d  = 1'b0;
      end
    endcase

`ifdef BTN_AUTOREPEAT_EN
    // Repeat phase starts at the hold pulse; no repeat on the releasing tick
    rcnt_d   = rcnt_q;
    rcnt_inc = rcnt_q + 1'b1;
    if (state_d == StIdle) begin
      rcnt_d = '0;
    end else if (held_q && tick_i) begin
      if (rcnt_inc == RepW'(REPEAT_TICKS)) begin
        rcnt_d  = '0;
        press_d = 1'b1;
      end else begin
        rcnt_d = rcnt_inc;
      end
    end
`endif
  end

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign stable_o  = (state_q == StDown) || (state_q == StDebRel);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
  assign held_o    = held_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: 2-flop synchroniser with optional
// inversion, shared debounce-tick prescaler and one btn_channel_fsm per input.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses while held.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter int unsigned TICK_DIV       = DefTickDiv,
  parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
  parameter int unsigned HOLD_TICKS     = DefHoldTicks,
  parameter int unsigned REPEAT_TICKS   = DefRepeatTicks
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_p,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] held,
  output logic                tick
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Released pin level, so s reads 0 straight out of reset
  localparam logic [CHANNELS-1:0] IdleLevel = ACTIVE_LOW ? '1 : '0;

  logic [CHANNELS-1:0] meta_q, sync_q, s;
  logic [PreW-1:0]     pre_q, pre_d;

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= IdleLevel;
      sync_q <= IdleLevel;
    end else begin
      meta_q <= raw_in;
      sync_q <= meta_q;
    end
  end

  assign s = ACTIVE_LOW ? ~sync_q : sync_q;

  // Prescaler wrap and tick strobe
  always_comb begin
    tick  = (pre_q == PreW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Prescaler counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

`ifndef BTN_AUTOREPEAT_EN
  // REPEAT_TICKS has no effect without auto-repeat; referenced only to elaborate it
  if (REPEAT_TICKS == 0) begin : g_repeat_unused
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_channel_fsm #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_TICKS  (REPEAT_TICKS)
`endif
    ) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .s_i      (s[i]),
      .tick_i   (tick),
      .stable_o (stable[i]),
      .press_o  (press[i]),
      .release_o(release_p[i]),
      .hold_o   (hold[i]),
      .held_o   (held[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (TICK_DIV=4, DEBOUNCE_TICKS=3,
// HOLD_TICKS=10, REPEAT_TICKS=5, ACTIVE_LOW=0). Stimulus pushes expected
// pulse events (channel, kind, cycle); a monitor pops them as pulses appear.
module tb_button_conditioner;

  localparam int KPress = 0;
  localparam int KRel   = 1;
  localparam int KHold  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] stable, press, release_p, hold, held;
  logic       tick;

  typedef struct {
    int ch;
    int kind;
    int at;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  button_conditioner #(
    .CHANNELS      (4),
    .ACTIVE_LOW    (1'b0),
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .HOLD_TICKS    (10),
    .REPEAT_TICKS  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .stable   (stable),
    .press    (press),
    .release_p(release_p),
    .hold     (hold),
    .held     (held),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    if (k == KPress) return "press";
    if (k == KRel) return "release_p";
    return "hold";
  endfunction

  // Monitor: pops the scoreboard whenever the DUT shows a pulse
  initial begin
    ev_t e;
    logic p;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at < cyc) begin
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_%s ch%0d: no pulse seen, required at cycle %0d", kname(e.kind),
                 e.ch, e.at);
      end
      for (int ch = 0; ch < 4; ch++) begin
        for (int k = 0; k < 3; k++) begin
          p = (k == KPress) ? press[ch] : (k == KRel) ? release_p[ch] : hold[ch];
          if (p) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_%s ch%0d: pulse at cycle %0d, none required", kname(k),
                       ch, cyc);
            end else begin
              e = sb.pop_front();
              if (e.ch != ch || e.kind != k || e.at != cyc) begin
                miscompares++;
                $display("FAIL event: got %s ch%0d at cycle %0d, required %s ch%0d at cycle %0d",
                         kname(k), ch, cyc, kname(e.kind), e.ch, e.at);
              end
            end
          end
        end
      end
    end
  end

  task automatic expect_ev(input int ch, input int kind, input int at);
    ev_t e;
    e.ch   = ch;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Returns at the falling edge of a cycle whose tick strobe is high
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 16);
    if (!tick) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: got no tick in 16 cycles, required one every 4");
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  initial begin
    int t;
    raw_in = 4'b0000;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {11'd0, stable, press, release_p, hold, held, tick}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {11'd0, stable, press, release_p, hold, held, tick}, 32'd0);

    // ch0: clean press, hold, one-tick release glitch, release
    wait_tick();
    t = cyc;
    raw_in[0] = 1'b1;
    expect_ev(0, KPress, t + 13);
    expect_ev(0, KHold, t + 53);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(0, KPress, t + 73);
    expect_ev(0, KPress, t + 93);
`endif
    ticks(4);
    chk("ch0_stable", {28'd0, stable}, 32'h1);
    ticks(11);
    chk("ch0_held", {28'd0, held}, 32'h1);
    raw_in[0] = 1'b0;
    ticks(1);
    raw_in[0] = 1'b1;
    ticks(2);
    chk("glitch_stable", {28'd0, stable}, 32'h1);
    chk("glitch_held", {28'd0, held}, 32'h1);
    ticks(3);
    raw_in[0] = 1'b0;
    expect_ev(0, KRel, t + 97);
    ticks(4);
    chk("ch0_released", {24'd0, stable, held}, 32'h0);

    // ch1: 2-tick burst rejected, 3-tick burst accepted
    wait_tick();
    t = cyc;
    raw_in[1] = 1'b1;
    ticks(2);
    raw_in[1] = 1'b0;
    ticks(1);
    raw_in[1] = 1'b1;
    expect_ev(1, KPress, t + 25);
    ticks(3);
    chk("bounce_not_yet", {28'd0, stable}, 32'h0);
    ticks(2);
    chk("bounce_stable", {28'd0, stable}, 32'h2);
    raw_in[1] = 1'b0;
    expect_ev(1, KRel, t + 45);
    ticks(4);
    chk("bounce_released", {28'd0, stable}, 32'h0);

    // ch2: long press
    wait_tick();
    t = cyc;
    raw_in[2] = 1'b1;
    expect_ev(2, KPress, t + 13);
    expect_ev(2, KHold, t + 53);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(2, KPress, t + 73);
`endif
    ticks(14);
    chk("long_held", {24'd0, stable, held}, 32'h44);
    ticks(2);
    raw_in[2] = 1'b0;
    expect_ev(2, KRel, t + 77);
    ticks(4);
    chk("long_released", {24'd0, stable, held}, 32'h0);

    // ch1 + ch2 together
    wait_tick();
    t = cyc;
    raw_in[2:1] = 2'b11;
    expect_ev(1, KPress, t + 13);
    expect_ev(2, KPress, t + 13);
    ticks(5);
    chk("dual_stable", {28'd0, stable}, 32'h6);
    raw_in[2:1] = 2'b00;
    expect_ev(1, KRel, t + 33);
    expect_ev(2, KRel, t + 33);
    ticks(4);
    chk("dual_released", {28'd0, stable}, 32'h0);

    // ch3: reset during DEB_PRESS, then a full debounce from scratch
    wait_tick();
    raw_in[3] = 1'b1;
    ticks(2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_outputs", {11'd0, stable, press, release_p, hold, held, tick}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_after", {11'd0, stable, press, release_p, hold, held, tick}, 32'd0);
    wait_tick();
    t = cyc;
    expect_ev(3, KPress, t + 9);
    ticks(2);
    chk("fresh_not_yet", {28'd0, stable}, 32'h0);
    ticks(1);
    chk("fresh_stable", {28'd0, stable}, 32'h8);
    raw_in[3] = 1'b0;
    expect_ev(3, KRel, t + 25);
    ticks(4);
    chk("fresh_released", {28'd0, stable}, 32'h0);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
